// File: rtl/rs_syndrome_bank.sv
// Parallel Reed-Solomon syndrome bank over GF(2^8) (poly 0x11D), LANES symbols per beat.
// Optional beat-count check compiled in with RS_SYND_LEN_CHECK_EN (adds out_len_err).
module rs_syndrome_bank #(
    parameter int LANES  = 16,
    parameter int NSYM   = 16,
    parameter int FCR    = 0,
    parameter int CW_LEN = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [8*NSYM-1:0]    out_synd,
    output logic                 out_zero,
    output logic                 out_valid,
`ifdef RS_SYND_LEN_CHECK_EN
    output logic                 out_len_err,
`endif
    input  logic                 out_ready
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] alpha_pow(input int e);
        logic [7:0] r;
        int n;
        r = 8'h01;
        n = e % 255;
        for (int i = 0; i < n; i++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    // Lane k carries degree LANES-1-k within the beat, so its weight is beta^(LANES-1-k).
    function automatic logic [8*LANES-1:0] coef_vec(input int e);
        logic [8*LANES-1:0] c;
        c = '0;
        for (int k = 0; k < LANES; k++) c[8*k +: 8] = alpha_pow(e * (LANES - 1 - k));
        return c;
    endfunction

    // Elaborates to a visible empty scope only when the parameter set is out of range.
    if (LANES < 1 || LANES > 32 || NSYM < 2 || NSYM > 32 || CW_LEN < LANES || CW_LEN > 255)
    begin : g_illegal_params
    end

    logic [8*NSYM-1:0] acc;
    logic [8*NSYM-1:0] acc_next;
    logic              accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    for (genvar j = 0; j < NSYM; j++) begin : g_synd
        localparam int               EXP  = (FCR + j) % 255;
        localparam logic [7:0]       STEP = alpha_pow(EXP * LANES);
        localparam logic [8*LANES-1:0] COEF = coef_vec(EXP);
        logic [7:0] sum;

        always_comb begin
            sum = gf_mul(acc[8*j +: 8], STEP);
            for (int k = 0; k < LANES; k++)
                sum = sum ^ gf_mul(in_data[8*k +: 8], COEF[8*k +: 8]);
        end

        assign acc_next[8*j +: 8] = sum;
    end

    // A last beat both publishes the result and restarts the accumulators on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            out_synd  <= '0;
            out_zero  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                if (in_last) begin
                    acc       <= '0;
                    out_synd  <= acc_next;
                    out_zero  <= (acc_next == '0);
                    out_valid <= 1'b1;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

`ifdef RS_SYND_LEN_CHECK_EN
    localparam int               CNT_W     = $clog2(255) + 1;
    localparam logic [CNT_W-1:0] EXP_BEATS = CNT_W'((CW_LEN + LANES - 1) / LANES);

    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_total;

    assign beat_total = beat_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt    <= '0;
            out_len_err <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                beat_cnt    <= '0;
                out_len_err <= (beat_total != EXP_BEATS);
            end else begin
                beat_cnt <= beat_total;
            end
        end
    end
`endif

endmodule

// File: doc/rs_syndrome_bank.md
# rs_syndrome_bank

Parametrised Reed-Solomon syndrome generator over GF(2^8), primitive polynomial 0x11D, alpha = 0x02. It accepts a codeword LANES symbols per beat over a valid/ready stream and computes all NSYM syndromes in parallel with per-syndrome Horner accumulation. It presents the syndromes as one flat bus behind a single output register with backpressure. It sits between the receive deframer and the key-equation solver, and supersedes the fixed 16-lane, single-syndrome slice.

## Interface
- LANES, default 16: symbols per input beat, 1..32.
- NSYM, default 16: number of syndromes (2t), 2..32.
- FCR, default 0: first consecutive root exponent; syndrome j uses beta_j = alpha^(FCR+j).
- CW_LEN, default 255: codeword length in symbols, LANES..255. Only used when the length check is compiled in.
- clk  in  1: clock; all logic on rising edge.
- rst_n  in  1: asynchronous active-low reset.
- in_data  in  8*LANES: beat symbols; lane 0 (bits 7:0) is earliest in time, i.e. highest polynomial degree.
- in_valid  in  1: beat present.
- in_last  in  1: final beat of codeword; qualified by in_valid.
- in_ready  out  1: beat accepted when in_valid && in_ready.
- out_synd  out  8*NSYM: syndrome j at bits 8j+7:8j.
- out_zero  out  1: all syndromes zero (no detectable error).
- out_valid  out  1: output register holds a result.
- out_ready  in  1: downstream consumes when out_valid && out_ready.
- out_len_err  out  1: beat count mismatch. Present only with RS_SYND_LEN_CHECK_EN.

## Operation
- Per syndrome j, accumulator acc_j (8 bit). On each accepted beat: acc_j_next = gfmul(acc_j, beta_j^LANES) ^ XOR over k of gfmul(d_k, beta_j^(LANES-1-k)).
- All constant powers are computed at elaboration by constant functions. No LUT ports and no runtime exponent arithmetic.
- The first beat of a codeword may be partial. The sender left-pads it with 0x00 in the low lanes. Leading zeros do not change syndromes.
- On an accepted non-last beat: acc_j <= acc_j_next.
- On an accepted last beat: out_synd[j] <= acc_j_next, out_zero <= (all acc_j_next == 0), out_valid <= 1, and all acc_j <= 0 in the same edge. Back-to-back codewords need no idle cycle.
- in_ready = !out_valid || out_ready, a registered-output skid rule. While the output is stalled, no beat is accepted, including non-last beats.
- out_valid clears on out_valid && out_ready, unless a last beat is accepted in the same cycle; in that case it stays 1 with the new data.
- out_synd and out_zero hold stable while out_valid && !out_ready.
- in_data and in_last are ignored when !in_valid. The accumulators hold.

## Timing
- Reset values: acc_j = 0, out_synd = 0, out_zero = 0, out_valid = 0, out_len_err = 0. in_ready = 1 after reset.
- Latency: out_valid rises on the edge that accepts the last beat, so it is visible the next cycle. This is 1 cycle of latency.
- Throughput: one beat per cycle, one codeword per ceil(CW_LEN/LANES) cycles sustained with out_ready = 1.
- The combinational path is one GF multiply plus an XOR tree of depth ceil(log2(LANES+1)). in_ready is combinational from out_valid and out_ready only.
- Reset mid-codeword discards the partial accumulation and any pending output. No out_valid pulse follows.
- A single-beat codeword (in_last on the first beat) is legal and produces a result.

## Configuration
- RS_SYND_LEN_CHECK_EN defined:
  - A beat counter (width clog2(255)+1) counts accepted beats and clears at each last beat.
  - out_len_err is registered with the result. It is 1 when the beat count including the last beat != ceil(CW_LEN/LANES).
  - The syndromes are still delivered.
- RS_SYND_LEN_CHECK_EN undefined: the counter and the out_len_err port do not exist. CW_LEN has no effect.

## Test plan
- Defaults, 16 beats of all 0x00 with in_last on beat 16 -> one cycle later out_valid = 1, all out_synd = 0x00, out_zero = 1.
- Defaults, all zeros except the final symbol (beat 16, lane 15) = 0x01 -> every syndrome = 0x01, out_zero = 0.
- Defaults, all zeros except beat 16, lane 14 = 0x01 (degree 1) -> S0 = 0x01, S1 = 0x02, S2 = 0x04, S3 = 0x08, S8 = 0x1D.
- Two codewords back-to-back with out_ready held 0 -> after the first result, in_ready = 0 and the second stream stalls. Raising out_ready gives the first result, then the second, with no corruption.
- With RS_SYND_LEN_CHECK_EN, LANES = 16, CW_LEN = 255: in_last on beat 15 -> out_len_err = 1; in_last on beat 16 -> out_len_err = 0.
- Assert rst_n low for 1 cycle after beat 8 of a codeword, then send a clean zero codeword -> no spurious out_valid, then out_zero = 1.
